// File: rtl/fetch_dec_pkg.sv
// Shared widths, slot ordering and packet layout for the fetch-to-decode packet buffer.
package fetch_dec_pkg;

   localparam int FETCH_WIDTH = 4;
   localparam int INST_W      = 16;
   localparam int VEC_W       = FETCH_WIDTH * INST_W;
   localparam int PKT_W       = 3 * VEC_W + FETCH_WIDTH;

   localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

   // Slot 0 occupies the most significant lane of every vector and the top bit of per-slot masks.
   localparam int SLOT0_BIT = FETCH_WIDTH - 1;

   typedef struct packed {
      logic [VEC_W-1:0]       pc;
      logic [VEC_W-1:0]       inst;
      logic [VEC_W-1:0]       recv_pc;
      logic [FETCH_WIDTH-1:0] pred;
   } pkt_t;

   function automatic int slot_bit(input int slot);
      return SLOT0_BIT - slot;
   endfunction

   function automatic logic [FETCH_WIDTH-1:0] slot_valid(input logic [VEC_W-1:0] inst);
      logic [FETCH_WIDTH-1:0] vld;
      vld = '0;
      for (int s = 0; s < FETCH_WIDTH; s++) begin
         vld[slot_bit(s)] = (inst[VEC_W-1-s*INST_W -: INST_W] != NOP_INST);
      end
      return vld;
   endfunction

endpackage

// File: rtl/fetch_dec_pkt_ram.sv
// Packet storage: DEPTH x PKT_W register array, one write port, one asynchronous read port.
module fetch_dec_pkt_ram
   import fetch_dec_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int PTR_W = 1
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [PTR_W-1:0] wr_addr,
   input  logic [PKT_W-1:0] wr_data,
   input  logic [PTR_W-1:0] rd_addr,
   output logic [PKT_W-1:0] rd_data
);

   logic [PKT_W-1:0] mem [DEPTH];

   // Contents are never reset; the top masks stale entries instead.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_dec_pkt_buf.sv
// Decode-side fetch packet FIFO with per-slot valid derivation and flush.
// Optional FETCH_DEC_BYPASS_EN: an empty buffer forwards the incoming packet combinationally.
module fetch_dec_pkt_buf
   import fetch_dec_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int PTR_W = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   fet_valid,
   output logic                   fet_ready,
   input  logic [VEC_W-1:0]       pc_from_fet,
   input  logic [VEC_W-1:0]       inst_from_fet,
   input  logic [VEC_W-1:0]       recv_pc_from_fet,
   input  logic [FETCH_WIDTH-1:0] pred_from_fet,
   input  logic                   flush,
   input  logic                   dec_ready,
   output logic                   dec_valid,
   output logic [VEC_W-1:0]       pc_to_dec,
   output logic [VEC_W-1:0]       inst_to_dec,
   output logic [VEC_W-1:0]       recv_pc_to_dec,
   output logic [FETCH_WIDTH-1:0] pred_to_dec,
   output logic [FETCH_WIDTH-1:0] slot_vld_to_dec,
   output logic [PTR_W:0]         occupancy
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             stored_valid;
   logic             bypass_take;
   logic             push;
   logic             pop;
   pkt_t             in_pkt;
   pkt_t             head_pkt;
   pkt_t             out_pkt;
   logic [PKT_W-1:0] ram_rd_data;

   assign in_pkt       = {pc_from_fet, inst_from_fet, recv_pc_from_fet, pred_from_fet};
   assign head_pkt     = ram_rd_data;
   assign stored_valid = (count != '0);
   assign fet_ready    = (count != FULL_CNT);

`ifdef FETCH_DEC_BYPASS_EN
   logic bypass_live;
   assign bypass_live = !stored_valid && fet_valid && !flush;
   assign dec_valid   = (stored_valid || bypass_live) && !flush;
   assign bypass_take = bypass_live && dec_ready;
   assign out_pkt     = bypass_live ? in_pkt : head_pkt;
`else
   assign dec_valid   = stored_valid;
   assign bypass_take = 1'b0;
   assign out_pkt     = head_pkt;
`endif

   // A packet consumed straight through the bypass is never written into storage.
   assign push = fet_valid && fet_ready && !bypass_take && !flush;
   assign pop  = stored_valid && dec_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   fetch_dec_pkt_ram #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data (in_pkt),
      .rd_addr (rd_ptr),
      .rd_data (ram_rd_data)
   );

   // Stale storage is hidden whenever nothing valid is presented.
   assign {pc_to_dec, inst_to_dec, recv_pc_to_dec, pred_to_dec} = dec_valid ? out_pkt : '0;
   assign slot_vld_to_dec = slot_valid(inst_to_dec);
   assign occupancy       = count;

endmodule

// File: tb/tb_fetch_dec_pkt_buf.sv
// Self-checking bench for fetch_dec_pkt_buf: directed vector table, hand sequences and a queue-model random run.
module tb_fetch_dec_pkt_buf;

   localparam int DEPTH = 2;

   typedef struct packed {
      logic [63:0] pc;
      logic [63:0] inst;
      logic [63:0] recv_pc;
      logic [3:0]  pred;
   } tb_pkt_t;

   typedef struct {
      logic    fv;
      logic    dr;
      logic    fl;
      tb_pkt_t pkt;
      logic    exp_dv;
      logic    exp_fr;
      logic [1:0] exp_occ;
      tb_pkt_t exp_head;
      logic [3:0] exp_sv;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        fet_valid;
   logic        fet_ready;
   logic [63:0] pc_from_fet;
   logic [63:0] inst_from_fet;
   logic [63:0] recv_pc_from_fet;
   logic [3:0]  pred_from_fet;
   logic        flush;
   logic        dec_ready;
   logic        dec_valid;
   logic [63:0] pc_to_dec;
   logic [63:0] inst_to_dec;
   logic [63:0] recv_pc_to_dec;
   logic [3:0]  pred_to_dec;
   logic [3:0]  slot_vld_to_dec;
   logic [1:0]  occupancy;

   int n_cmp = 0;
   int n_err = 0;
   tb_pkt_t mq[$];
   vec_t tbl[12];

   fetch_dec_pkt_buf #(.DEPTH(DEPTH), .PTR_W(1)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .fet_valid        (fet_valid),
      .fet_ready        (fet_ready),
      .pc_from_fet      (pc_from_fet),
      .inst_from_fet    (inst_from_fet),
      .recv_pc_from_fet (recv_pc_from_fet),
      .pred_from_fet    (pred_from_fet),
      .flush            (flush),
      .dec_ready        (dec_ready),
      .dec_valid        (dec_valid),
      .pc_to_dec        (pc_to_dec),
      .inst_to_dec      (inst_to_dec),
      .recv_pc_to_dec   (recv_pc_to_dec),
      .pred_to_dec      (pred_to_dec),
      .slot_vld_to_dec  (slot_vld_to_dec),
      .occupancy        (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic tb_pkt_t mk(input logic [63:0] pc, input logic [63:0] inst,
                                  input logic [63:0] rpc, input logic [3:0] pred);
      tb_pkt_t p;
      p.pc = pc; p.inst = inst; p.recv_pc = rpc; p.pred = pred;
      return p;
   endfunction

   // Slot s is the s-th 16-bit lane from the top; its valid flag is mask bit 3-s.
   function automatic logic [3:0] exp_slots(input logic [63:0] inst);
      logic [3:0] m;
      logic [15:0] lane;
      m = 4'b0000;
      for (int s = 0; s < 4; s++) begin
         lane = inst[63-16*s -: 16];
         if (lane != 16'h0000) m[3-s] = 1'b1;
      end
      return m;
   endfunction

   function automatic tb_pkt_t rand_pkt();
      tb_pkt_t p;
      p.pc      = {$urandom, $urandom};
      p.recv_pc = {$urandom, $urandom};
      p.pred    = 4'($urandom);
      for (int s = 0; s < 4; s++) begin
         p.inst[63-16*s -: 16] = ($urandom % 3 == 0) ? 16'h0000 : 16'($urandom);
      end
      return p;
   endfunction

   task automatic check_output(input string name, input logic [195:0] act, input logic [195:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic fv, input logic dr, input logic fl, input tb_pkt_t p);
      fet_valid        = fv;
      dec_ready        = dr;
      flush            = fl;
      pc_from_fet      = p.pc;
      inst_from_fet    = p.inst;
      recv_pc_from_fet = p.recv_pc;
      pred_from_fet    = p.pred;
   endtask

   function automatic tb_pkt_t dut_head();
      return {pc_to_dec, inst_to_dec, recv_pc_to_dec, pred_to_dec};
   endfunction

   // One clock with expectations from the queue model; entered and left 1 time unit after a rising edge.
   task automatic model_cycle(input string tag, input logic fv, input logic dr, input logic fl, input tb_pkt_t p);
      logic    e_dv, e_fr, byp, push_ok;
      tb_pkt_t e_head;
      apply_stimulus(fv, dr, fl, p);
      #1;
      e_fr   = (mq.size() < DEPTH);
      byp    = 1'b0;
`ifdef FETCH_DEC_BYPASS_EN
      byp    = (mq.size() == 0) && fv && !fl;
      e_dv   = byp || ((mq.size() != 0) && !fl);
`else
      e_dv   = (mq.size() != 0);
`endif
      e_head = '0;
      if (e_dv) e_head = byp ? p : mq[0];
      check_output({tag, ".dec_valid"}, dec_valid, e_dv);
      check_output({tag, ".fet_ready"}, fet_ready, e_fr);
      check_output({tag, ".occupancy"}, occupancy, mq.size());
      check_output({tag, ".head"}, dut_head(), e_head);
      check_output({tag, ".slot_vld"}, slot_vld_to_dec, exp_slots(e_head.inst));
      @(posedge clk);
      if (fl) begin
         mq.delete();
      end else begin
         push_ok = fv && e_fr && !(byp && dr);
         if (!byp && mq.size() != 0 && dr) void'(mq.pop_front());
         if (push_ok) mq.push_back(p);
      end
      #1;
   endtask

   initial begin
      tb_pkt_t pa, pb, pc, pd, pe, pf, z;
      z  = '0;
      pa = mk(64'h0010_0011_0012_0013, 64'h1234_0000_5678_0000, 64'h0020_0021_0022_0023, 4'b1000);
      pb = mk(64'h0100_0102_0104_0106, 64'h0000_1111_0000_2222, 64'h0200_0202_0204_0206, 4'b0101);
      pc = mk(64'h0300_0302_0304_0306, 64'h3333_4444_5555_6666, 64'h0400_0402_0404_0406, 4'b0011);
      pd = mk(64'h0500_0502_0504_0506, 64'h0000_0000_0000_abcd, 64'h0600_0602_0604_0606, 4'b0001);
      pe = mk(64'h0700_0702_0704_0706, 64'h7777_0000_0000_0000, 64'h0800_0802_0804_0806, 4'b1110);
      pf = mk(64'h0900_0902_0904_0906, 64'hffff_ffff_0000_0000, 64'h0a00_0a02_0a04_0a06, 4'b1111);

      // Each row's expectations hold just before the edge that applies its inputs.
      tbl[0]  = '{1'b0, 1'b0, 1'b0, z,  1'b0, 1'b1, 2'd0, z,  4'b0000};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, pa, 1'b0, 1'b1, 2'd0, z,  4'b0000};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, z,  1'b1, 1'b1, 2'd1, pa, 4'b1010};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, pb, 1'b0, 1'b1, 2'd0, z,  4'b0000};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, pc, 1'b1, 1'b1, 2'd1, pb, 4'b0101};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, pd, 1'b1, 1'b0, 2'd2, pb, 4'b0101};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, pd, 1'b1, 1'b0, 2'd2, pb, 4'b0101};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, pd, 1'b1, 1'b0, 2'd2, pb, 4'b0101};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, pd, 1'b1, 1'b1, 2'd1, pc, 4'b1111};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, pe, 1'b1, 1'b1, 2'd1, pd, 4'b0001};
      tbl[10] = '{1'b1, 1'b1, 1'b1, pf, 1'b1, 1'b0, 2'd2, pd, 4'b0001};
      tbl[11] = '{1'b0, 1'b1, 1'b0, z,  1'b0, 1'b1, 2'd0, z,  4'b0000};

      rst_n = 1'b0;
      apply_stimulus(1'b0, 1'b0, 1'b0, z);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check_output("reset.dec_valid", dec_valid, 1'b0);
      check_output("reset.fet_ready", fet_ready, 1'b1);
      check_output("reset.occupancy", occupancy, 2'd0);
      check_output("reset.inst", inst_to_dec, 64'h0);
      @(posedge clk);
      #1;

`ifndef FETCH_DEC_BYPASS_EN
      for (int i = 0; i < 12; i++) begin
         apply_stimulus(tbl[i].fv, tbl[i].dr, tbl[i].fl, tbl[i].pkt);
         #1;
         check_output($sformatf("vec%0d.dec_valid", i), dec_valid, tbl[i].exp_dv);
         check_output($sformatf("vec%0d.fet_ready", i), fet_ready, tbl[i].exp_fr);
         check_output($sformatf("vec%0d.occupancy", i), occupancy, tbl[i].exp_occ);
         check_output($sformatf("vec%0d.head", i), dut_head(), tbl[i].exp_head);
         check_output($sformatf("vec%0d.slot_vld", i), slot_vld_to_dec, tbl[i].exp_sv);
         @(posedge clk);
         #1;
      end
`endif

      // Steady push+pop at occupancy 1 across several pointer wraps.
      model_cycle("wrap_fill", 1'b1, 1'b0, 1'b0, rand_pkt());
      for (int i = 0; i < 10; i++) model_cycle("wrap", 1'b1, 1'b1, 1'b0, rand_pkt());
      model_cycle("wrap_drain", 1'b0, 1'b1, 1'b0, z);
      model_cycle("wrap_empty", 1'b0, 1'b1, 1'b0, z);

      // Flush with a concurrent push at occupancy 2.
      model_cycle("fl_fill0", 1'b1, 1'b0, 1'b0, rand_pkt());
      model_cycle("fl_fill1", 1'b1, 1'b0, 1'b0, rand_pkt());
      model_cycle("fl_hit", 1'b1, 1'b1, 1'b1, pf);
      model_cycle("fl_after", 1'b0, 1'b0, 1'b0, z);

      // Pop while empty must not underflow.
      model_cycle("empty_pop0", 1'b0, 1'b1, 1'b0, z);
      model_cycle("empty_pop1", 1'b1, 1'b0, 1'b0, pa);

      // Asynchronous reset between edges at occupancy 2.
      model_cycle("ar_fill", 1'b1, 1'b0, 1'b0, pb);
      apply_stimulus(1'b0, 1'b0, 1'b0, z);
      check_output("ar.pre_occupancy", occupancy, 2'd2);
      #3;
      rst_n = 1'b0;
      #1;
      check_output("ar.dec_valid", dec_valid, 1'b0);
      check_output("ar.occupancy", occupancy, 2'd0);
      check_output("ar.fet_ready", fet_ready, 1'b1);
      check_output("ar.inst", inst_to_dec, 64'h0);
      #2;
      rst_n = 1'b1;
      mq.delete();
      @(posedge clk);
      #1;

`ifdef FETCH_DEC_BYPASS_EN
      model_cycle("byp_take", 1'b1, 1'b1, 1'b0, pa);
      check_output("byp_take.occ_after", occupancy, 2'd0);
      model_cycle("byp_hold", 1'b1, 1'b0, 1'b0, pb);
      model_cycle("byp_flush", 1'b1, 1'b1, 1'b1, pc);
      model_cycle("byp_fl_in", 1'b1, 1'b1, 1'b1, pd);
`endif

      for (int i = 0; i < 400; i++) begin
         model_cycle("rand", ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 20) == 0, rand_pkt());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
